// File: rtl/fsm_bit_serializer.sv
// Parallel-to-serial front end feeding the ROM LUT FSM x_in, one bit per clock.
// Latency: first bit on x_out the cycle after the accept edge; words stream back-to-back.
// Backpressure: load_ready = ~hold_full; a second word is buffered while the first shifts.
module fsm_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             x_out_q, x_out_d;
    logic             x_valid_q, x_valid_d;
    logic             word_done_q, word_done_d;

    logic             accept;
    logic [WIDTH-1:0] sh_shifted;

    assign load_ready = ~hold_full_q;
    assign accept     = load_valid & ~hold_full_q;
    assign busy       = (state_q == SHIFT) | hold_full_q;
    assign x_out      = x_out_q;
    assign x_valid    = x_valid_q;
    assign word_done  = word_done_q;

    // Next state for the shifter, holding register and the registered serial outputs.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;

        // Shift toward the output end, zero-filling the vacated bit.
        if (MSB_FIRST) begin
            sh_shifted = {sh_q[WIDTH-2:0], 1'b0};
        end else begin
            sh_shifted = {1'b0, sh_q[WIDTH-1:1]};
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d      = data_in;
                    bit_cnt_d = LAST;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != '0) begin
                    sh_d      = sh_shifted;
                    bit_cnt_d = bit_cnt_q - CW'(1);
                    if (accept) begin
                        hold_d      = data_in;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // Held word takes over with no bubble; load_ready was low so no accept here.
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = LAST;
                end else if (accept) begin
                    // Bypass the empty holding register straight into the shifter.
                    sh_d      = data_in;
                    bit_cnt_d = LAST;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered images of the next shifter state, so IDLE shows zeros.
        x_valid_d   = (state_d == SHIFT);
        x_out_d     = x_valid_d & (MSB_FIRST ? sh_d[WIDTH-1] : sh_d[0]);
        word_done_d = x_valid_d & (bit_cnt_d == '0);
    end

    // State and datapath registers with synchronous reset that discards any in-flight words.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            x_out_q     <= 1'b0;
            x_valid_q   <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            x_out_q     <= x_out_d;
            x_valid_q   <= x_valid_d;
            word_done_q <= word_done_d;
        end
    end

endmodule

// File: tb/tb_fsm_bit_serializer.sv
// Bench for fsm_bit_serializer: bit-queue reference model plus directed streams.
module tb_fsm_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data_in;
    logic         load_valid;
    logic         load_ready, x_out, x_valid, word_done, busy;

    logic [W-1:0] data2;
    logic         valid2;
    logic         load_ready2, x_out2, x_valid2, word_done2, busy2;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    fsm_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
        .load_ready(load_ready), .x_out(x_out), .x_valid(x_valid),
        .word_done(word_done), .busy(busy)
    );

    fsm_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .data_in(data2), .load_valid(valid2),
        .load_ready(load_ready2), .x_out(x_out2), .x_valid(x_valid2),
        .word_done(word_done2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted word becomes W queued bits; one bit leaves per clock.
    // The holding slot is free exactly when fewer than W bits are still waiting to be shown.
    logic [1:0] q[$];
    logic       e_vld = 1'b0, e_out = 1'b0, e_done = 1'b0;
    logic       m_acc = 1'b0;
    logic       started = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            e_vld   = 1'b0;
            e_out   = 1'b0;
            e_done  = 1'b0;
            m_acc   = 1'b0;
            started = 1'b1;
        end else begin
            logic [1:0] ent;
            m_acc = load_valid && (q.size() < W);
            if (m_acc)
                for (int i = 0; i < W; i++)
                    q.push_back({(i == W - 1), data_in[W-1-i]});
            if (q.size() > 0) begin
                ent    = q.pop_front();
                e_vld  = 1'b1;
                e_out  = ent[0];
                e_done = ent[1];
            end else begin
                e_vld  = 1'b0;
                e_out  = 1'b0;
                e_done = 1'b0;
            end
        end
    end

    // Per-cycle compare of the MSB-first instance against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("x_valid",    x_valid,    e_vld);
            chk("x_out",      x_out,      e_out);
            chk("word_done",  word_done,  e_done);
            chk("load_ready", load_ready, (q.size() < W));
            chk("busy",       busy,       e_vld);
        end
    end

    // Stream capture for literal checks on both instances.
    logic bits [0:1023];
    int   dones [0:255];
    int   ncap = 0, ndone = 0;
    logic bits2 [0:255];
    int   dones2 [0:63];
    int   ncap2 = 0, ndone2 = 0;

    always @(negedge clk) begin
        if (started) begin
            if (word_done === 1'b1) begin dones[ndone] = ncap; ndone++; end
            if (x_valid === 1'b1) begin bits[ncap] = x_out; ncap++; end
            if (word_done2 === 1'b1) begin dones2[ndone2] = ncap2; ndone2++; end
            if (x_valid2 === 1'b1) begin bits2[ncap2] = x_out2; ncap2++; end
        end
    end

    function automatic logic [31:0] get_word(input int s, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w = {w[30:0], bits[s+i]};
        return w;
    endfunction

    function automatic logic [31:0] get_word2(input int s, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w = {w[30:0], bits2[s+i]};
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [W-1:0] d);
        data_in    = d;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        int s, d0, s2, d2, waited;
        bit got;

        reset = 1'b1; load_valid = 1'b0; data_in = '0; valid2 = 1'b0; data2 = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_x_valid", x_valid, 0);
        chk("rst_ready",   load_ready, 1);
        chk("rst_busy",    busy, 0);
        step();

        // 1: single word, MSB first
        s = ncap; d0 = ndone;
        put(8'hB2);
        repeat (10) step();
        chk("t1_stream", get_word(s, 8), 32'h000000B2);
        chk("t1_nbits",  ncap - s, 8);
        chk("t1_ndone",  ndone - d0, 1);
        chk("t1_donepos", dones[d0] - s, 7);
        chk("t1_idle_busy", busy, 0);

        // 2: second word queued into hold at bit 3
        s = ncap; d0 = ndone;
        put(8'hB2);
        step(); step();
        put(8'h0F);
        chk("t2_ready_low", load_ready, 0);
        repeat (20) step();
        chk("t2_stream", get_word(s, 16), 32'h0000B20F);
        chk("t2_nbits",  ncap - s, 16);
        chk("t2_ndone",  ndone - d0, 2);
        chk("t2_done_gap", dones[d0+1] - dones[d0], 8);

        // 3: third word held off by backpressure until the hold slot frees
        s = ncap; d0 = ndone;
        put(8'hB2);
        step(); step();
        data_in = 8'h0F; load_valid = 1'b1;
        step();
        data_in = 8'h55;
        got = 1'b0; waited = 0;
        while (!got && waited < 40) begin
            step();
            waited++;
            if (m_acc) got = 1'b1;
        end
        load_valid = 1'b0;
        chk("t3_55_accepted", got, 1);
        chk("t3_wait_cycles", waited, 6);
        repeat (30) step();
        chk("t3_stream", get_word(s, 24), 32'h00B20F55);
        chk("t3_nbits",  ncap - s, 24);
        chk("t3_ndone",  ndone - d0, 3);

        // 4: bypass load exactly on the last-bit edge
        s = ncap; d0 = ndone;
        put(8'hB2);
        repeat (7) step();
        put(8'hA5);
        chk("t4_hold_empty", load_ready, 1);
        repeat (12) step();
        chk("t4_stream", get_word(s, 16), 32'h0000B2A5);
        chk("t4_nbits",  ncap - s, 16);
        chk("t4_ndone",  ndone - d0, 2);

        // 5: reset mid-word with a held word, then a fresh word
        put(8'hB2);
        step(); step();
        put(8'h0F);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_x_valid",   x_valid, 0);
        chk("t5_x_out",     x_out, 0);
        chk("t5_word_done", word_done, 0);
        chk("t5_ready",     load_ready, 1);
        chk("t5_busy",      busy, 0);
        s = ncap; d0 = ndone;
        put(8'h81);
        repeat (10) step();
        chk("t5_stream", get_word(s, 8), 32'h00000081);
        chk("t5_nbits",  ncap - s, 8);
        chk("t5_ndone",  ndone - d0, 1);

        // 6: LSB-first instance
        s2 = ncap2; d2 = ndone2;
        data2 = 8'hB2; valid2 = 1'b1;
        step();
        valid2 = 1'b0;
        repeat (10) step();
        chk("t6_stream",  get_word2(s2, 8), 32'h0000004D);
        chk("t6_nbits",   ncap2 - s2, 8);
        chk("t6_ndone",   ndone2 - d2, 1);
        chk("t6_donepos", dones2[d2] - s2, 7);
        chk("t6_busy",    busy2, 0);
        chk("t6_ready",   load_ready2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
